// File: rtl/sdp_sram_pkg.sv
// sdp_sram_pkg: shared definitions for the simple-dual-port byte-enable SRAM.
//   RDW_OLD / RDW_NEW / RDW_X : same-address read-during-write policies
//   clr_state_e               : clear-sequencer state encoding
//   byte_parity()             : even-parity bit of a (zero-extended) byte
package sdp_sram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    localparam int RDW_X   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam int PAR_MAX_W = 64;

    // The stored bit makes the byte plus parity contain an even number of ones.
    function automatic logic byte_parity(input logic [PAR_MAX_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sdp_sram_array.sv
// sdp_sram_array: bare storage for sdp_sram_be. No reset.
//   clk          : clock
//   we           : write strobe
//   waddr/wdata  : write address / lane-packed write word
//   wlane        : per-lane write enable (lane i = bits [i*LANE_W +: LANE_W])
//   raddr/rdata  : combinational read port
module sdp_sram_array
    import sdp_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int LANES      = 2,
    parameter int LANE_W     = 8
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  logic [LANES-1:0]          wlane,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    output logic [LANES*LANE_W-1:0]   rdata
);

    logic [LANES*LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wlane[i]) begin
                    mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdp_sram_be.sv
// sdp_sram_be: simple-dual-port SRAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write policy and a post-reset clear sequencer.
// Optional build macro SDP_SRAM_PARITY_EN adds one even-parity bit per byte
// and the par_err output.
//   clk, rst                    : clock, async active-high reset
//   wr_en/wr_addr/wr_data/wr_be : write port with per-byte enables
//   rd_en/rd_addr               : read request
//   rd_data/rd_valid            : registered read data and one-cycle strobe
//   busy                        : clear in progress, requests dropped
//   par_err (parity build only) : parity mismatch, pulses with rd_valid
//
// state    | meaning
// ST_CLEAR | zeroing mem[cnt], one word per cycle, busy=1
// ST_IDLE  | normal operation until next rst
module sdp_sram_be
    import sdp_sram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int BYTE_WIDTH   = 8,
    parameter int DEPTH        = 2**ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             busy
`ifdef SDP_SRAM_PARITY_EN
    ,
    output logic                             par_err
`endif
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
`ifdef SDP_SRAM_PARITY_EN
    localparam int LANE_W = BYTE_WIDTH + 1;
`else
    localparam int LANE_W = BYTE_WIDTH;
`endif
    localparam int MW = NB * LANE_W;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_CLEAR);
    end

    logic wr_acc, rd_acc, rd_in_range, collide;
    assign wr_acc      = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_acc      = rd_en && !busy;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
    assign collide     = wr_acc && (wr_addr == rd_addr);

    logic [MW-1:0]         wr_lanes, arr_wdata, arr_rdata;
    logic [NB-1:0]         arr_wlane;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_waddr;

    always_comb begin
        wr_lanes = '0;
        for (int i = 0; i < NB; i++) begin
            wr_lanes[i*LANE_W +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDP_SRAM_PARITY_EN
            wr_lanes[i*LANE_W + BYTE_WIDTH] =
                byte_parity(PAR_MAX_W'(wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]));
`endif
        end
    end

    // The clear sequencer owns the array port while busy; data and parity are zero.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = wr_addr;
        arr_wdata = '0;
        arr_wlane = '0;
        if (busy) begin
            arr_we    = 1'b1;
            arr_waddr = cnt_q;
            arr_wlane = '1;
        end else if (wr_acc) begin
            arr_we    = 1'b1;
            arr_wdata = wr_lanes;
            arr_wlane = wr_be;
        end
    end

    sdp_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .LANES      (NB),
        .LANE_W     (LANE_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wlane (arr_wlane),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

    // Read word as seen at the accepting edge; the array read is pre-write,
    // so RDW_OLD needs no special handling.
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_err;
    always_comb begin
        s1_data = '0;
        s1_err  = 1'b0;
        if (rd_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (collide && (RDW_MODE == RDW_NEW) && wr_be[i]) begin
                    s1_data[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end else begin
                    s1_data[i*BYTE_WIDTH +: BYTE_WIDTH] = arr_rdata[i*LANE_W +: BYTE_WIDTH];
`ifdef SDP_SRAM_PARITY_EN
                    if (byte_parity(PAR_MAX_W'(arr_rdata[i*LANE_W +: BYTE_WIDTH]))
                            != arr_rdata[i*LANE_W + BYTE_WIDTH]) begin
                        s1_err = 1'b1;
                    end
`endif
                end
            end
            if (collide && (RDW_MODE == RDW_X)) begin
                s1_data = 'x;
                s1_err  = 1'b0;
            end
        end
    end

    logic                  p_valid_q, p_valid_d, p_err_q, p_err_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  rd_valid_q, rd_valid_d, par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        p_valid_d = rd_acc;
        p_data_d  = rd_acc ? s1_data : p_data_q;
        p_err_d   = rd_acc && s1_err;
        if (READ_LATENCY == 2) begin
            rd_valid_d = p_valid_q;
            rd_data_d  = p_valid_q ? p_data_q : rd_data_q;
            par_err_d  = p_valid_q && p_err_q;
        end else begin
            rd_valid_d = rd_acc;
            rd_data_d  = rd_acc ? s1_data : rd_data_q;
            par_err_d  = rd_acc && s1_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid_q  <= 1'b0;
            p_data_q   <= '0;
            p_err_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            par_err_q  <= 1'b0;
        end else begin
            p_valid_q  <= p_valid_d;
            p_data_q   <= p_data_d;
            p_err_q    <= p_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            par_err_q  <= par_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`ifdef SDP_SRAM_PARITY_EN
    assign par_err  = par_err_q;
`else
    logic unused_par;
    assign unused_par = par_err_q ^ p_err_q;
`endif

endmodule

// File: doc/sdp_sram_be.md
Name: sdp_sram_be

Overview:
- Parametrised simple-dual-port behavioural SRAM, successor to the single-port FIR-project SRAM: one write port, one independent read port.
- Adds per-byte write enables, selectable read latency (1 or 2), a defined read-during-write policy, a read-valid strobe and a reset-triggered memory-clear sequencer.
- Used as coefficient/sample storage in the FIR and FPU datapaths where a read and a write occur in the same cycle.

Parameters:
ADDR_WIDTH, 4, address bits
DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, write-enable granularity
DEPTH, 2**ADDR_WIDTH, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, 1 or 2 clock edges from read request to data
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (byte-merged), 2 = all-X
INIT_CLEAR, 1, 1 = zero the whole array after reset

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_be  in  DATA_WIDTH/BYTE_WIDTH  byte enables; bit i covers byte i (LSB first)
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  one-cycle strobe marking rd_data valid
busy  out  1  clear sequence in progress; requests are ignored

Behaviour:
- Reset values: rd_data=0, rd_valid=0, read pipeline stages cleared, busy=INIT_CLEAR, FSM=CLEAR if INIT_CLEAR else IDLE, clear counter=0. The array itself is not reset by rst.
- Clear FSM, two states:
  - CLEAR: writes all-zero (including parity, if built) to mem[cnt] each cycle; cnt increments; when cnt==DEPTH-1, that word is written and the FSM moves to IDLE.
  - IDLE: terminal until the next rst.
  - busy is high exactly when the FSM is in CLEAR: DEPTH cycles after rst deasserts.
  - rst asserted mid-clear restarts the sequence at cnt=0.
- When busy=1, wr_en and rd_en are dropped: no array update, no rd_valid, rd_data holds.
- Write: on an edge with wr_en=1 and busy=0, byte i of mem[wr_addr] takes wr_data byte i only where wr_be[i]=1. wr_be=0 is a no-op.
- Read, request accepted at edge N:
  - READ_LATENCY=1: rd_data and rd_valid update at edge N.
  - READ_LATENCY=2: they update at edge N+1.
  - rd_valid is high for one cycle per accepted request; back-to-back requests give back-to-back strobes.
  - rd_data holds its last value when no strobe is pending (never reverts to X).
- Read-during-write, wr_addr==rd_addr with both enabled at the same edge:
  - RDW_MODE 0: read returns the pre-write word.
  - RDW_MODE 1: bytes with wr_be=1 come from wr_data, other bytes are the old word.
  - RDW_MODE 2: rd_data is all-X, with rd_valid still asserted (preserves the previous generation's behaviour).
  - Different addresses never interact.
- Out of range (addr >= DEPTH): writes are ignored; reads return 0 with rd_valid asserted.
- rst asserted mid-read: pending strobes are discarded and rd_data returns to 0 immediately (asynchronously).

Optional Feature:
- SDP_SRAM_PARITY_EN defined:
  - One even-parity bit is stored per byte, written with the byte.
  - On a read, parity is recomputed; output par_err (1 bit, reset 0) pulses together with rd_valid if any byte mismatches.
  - A bypassed RDW_MODE 1 byte uses freshly computed parity.
  - RDW_MODE 2 reads report par_err=0.
- Undefined: no parity storage, no par_err port.

Decomposition:
- Package sdp_sram_pkg holds:
  - RDW_OLD, RDW_NEW and RDW_X localparams (0/1/2).
  - The clear-FSM state encoding (ST_IDLE, ST_CLEAR).
  - A byte-parity function.
- Natural sub-module: sdp_sram_array, the bare storage with byte-enable write and a combinational/registered read, no reset.
- The top level owns the clear FSM, the arbitration of the clear port against the write port, RDW handling and the latency pipeline.

Test Plan:
- rst pulse, INIT_CLEAR=1, DEPTH=16 -> busy high for exactly 16 cycles after deassert. A wr_en issued while busy is dropped. Reads of addresses 0..15 afterwards return 0x0000.
- Write 0xA55A to addr 3 with wr_be=2'b01, after prior content 0x1234 -> read of addr 3 returns 0x125A. With READ_LATENCY=2, rd_valid appears 2 edges after rd_en.
- Same-address write 0xBEEF (wr_be=2'b10) over old word 0x1111, at each RDW_MODE -> mode 0 returns 0x1111, mode 1 returns 0xBE11, mode 2 returns all-X. rd_valid=1 in all three.
- Reads of addrs 0,1,2 issued on back-to-back cycles -> three consecutive rd_valid strobes with data in order. rd_data holds the addr-2 value afterwards.
- rst asserted at clear cnt=7, then released -> clear restarts at cnt=0 and busy lasts the full 16 cycles. A read pending at rst produces no strobe.
- With SDP_SRAM_PARITY_EN: flip one stored data bit of addr 5 by hierarchical deposit, then read addr 5 -> par_err=1 in the same cycle as rd_valid. Clean addresses give par_err=0.
